ahb_manager_arbiter: RTL and testbench

Shares one AHB-Lite subordinate-side bus between NUM_MANAGERS AHB-Lite manager ports, such as several renode_ahb_manager instances or RTL managers, using round-robin arbitration. Each manager's address phase is captured into a per-port holding register. The winning request is issued on the shared bus, and the response is routed back only to its owner. The block sits between the managers and a single subordinate (or subordinate-side interconnect) in co-simulation testbenches.

---
 rtl/ahb_manager_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ahb_manager_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_manager_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite subordinate between several AHB-Lite managers.
// Each manager's address phase is held per port until it wins the shared address slot.
module ahb_manager_arbiter #(
    parameter int unsigned NUM_MANAGERS = 2,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                               HCLK,
    input  logic                               HRESET,
    input  logic [2*NUM_MANAGERS-1:0]          m_HTRANS,
    input  logic [ADDR_WIDTH*NUM_MANAGERS-1:0] m_HADDR,
    input  logic [NUM_MANAGERS-1:0]            m_HWRITE,
    input  logic [3*NUM_MANAGERS-1:0]          m_HSIZE,
    input  logic [3*NUM_MANAGERS-1:0]          m_HBURST,
    input  logic [DATA_WIDTH*NUM_MANAGERS-1:0] m_HWDATA,
    output logic [DATA_WIDTH-1:0]              m_HRDATA,
    output logic [NUM_MANAGERS-1:0]            m_HREADY,
    output logic [NUM_MANAGERS-1:0]            m_HRESP,
    output logic [1:0]                         s_HTRANS,
    output logic [ADDR_WIDTH-1:0]              s_HADDR,
    output logic                               s_HWRITE,
    output logic [2:0]                         s_HSIZE,
    output logic [2:0]                         s_HBURST,
    output logic [DATA_WIDTH-1:0]              s_HWDATA,
    output logic                               s_HREADY,
    input  logic [DATA_WIDTH-1:0]              s_HRDATA,
    input  logic                               s_HREADYOUT,
    input  logic                               s_HRESP,
    output logic [NUM_MANAGERS-1:0]            grant
);

    localparam int unsigned N  = NUM_MANAGERS;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_PEND = 2'd1,
        P_ADDR = 2'd2,
        P_DATA = 2'd3
    } port_st_t;

    port_st_t                st         [N];
    logic [ADDR_WIDTH-1:0]   hold_addr  [N];
    logic                    hold_write [N];
    logic [2:0]              hold_size  [N];
    logic [2:0]              hold_burst [N];

    logic                    lock;
    logic [PW-1:0]           lock_port;
    logic [PW-1:0]           rr_ptr;

    logic [N-1:0]            pend;
    logic [N-1:0]            cap;
    logic [1:0]              lock_trans;
    logic                    lock_done;
    logic                    win_vld;
    logic [PW-1:0]           win_idx;

    assign m_HRDATA = s_HRDATA;
    assign s_HREADY = s_HREADYOUT;
    assign s_HBURST = 3'b000;

    // Per-port capture qualifier: the manager sees HREADY high exactly in IDLE or a completing DATA.
    always_comb begin
        pend       = '0;
        cap        = '0;
        lock_trans = HTRANS_IDLE;
        for (int unsigned i = 0; i < N; i++) begin
            pend[i] = (st[i] == P_PEND);
            cap[i]  = m_HTRANS[2*i+1] &&
                      ((st[i] == P_IDLE) || ((st[i] == P_DATA) && s_HREADYOUT));
            if (lock_port == PW'(i)) begin
                lock_trans = m_HTRANS[2*i +: 2];
            end
        end
    end

    // A burst stays atomic until its owner completes a beat without following it with SEQ.
    assign lock_done = lock && s_HREADYOUT && (st[lock_port] == P_DATA) &&
                       (lock_trans != HTRANS_SEQ);

    // Round-robin search from rr_ptr+1; descending offsets so the nearest pending port wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        if (lock) begin
            if (st[lock_port] == P_PEND) begin
                win_vld = 1'b1;
                win_idx = lock_port;
            end
        end else begin
            for (int unsigned k = N; k > 0; k--) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if ((i == ((32'(rr_ptr) + k) % N)) && pend[i]) begin
                        win_vld = 1'b1;
                        win_idx = PW'(i);
                    end
                end
            end
        end
    end

    // Port-facing response steering and write-data mux for the data-phase owner.
    always_comb begin
        m_HREADY = '1;
        m_HRESP  = '0;
        s_HWDATA = '0;
        for (int unsigned i = 0; i < N; i++) begin
            case (st[i])
                P_PEND, P_ADDR: m_HREADY[i] = 1'b0;
                P_DATA: begin
                    m_HREADY[i] = s_HREADYOUT;
                    m_HRESP[i]  = s_HRESP;
                    s_HWDATA    = m_HWDATA[DATA_WIDTH*i +: DATA_WIDTH];
                end
                default: ;
            endcase
        end
    end

    // Port state machines, holding registers, shared address-phase outputs and lock.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int unsigned i = 0; i < N; i++) begin
                st[i]         <= P_IDLE;
                hold_addr[i]  <= '0;
                hold_write[i] <= 1'b0;
                hold_size[i]  <= 3'b000;
                hold_burst[i] <= 3'b000;
            end
            s_HTRANS  <= HTRANS_IDLE;
            s_HADDR   <= '0;
            s_HWRITE  <= 1'b0;
            s_HSIZE   <= 3'b000;
            grant     <= '0;
            lock      <= 1'b0;
            lock_port <= '0;
            rr_ptr    <= PW'(N - 1);
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cap[i]) begin
                    hold_addr[i]  <= m_HADDR[ADDR_WIDTH*i +: ADDR_WIDTH];
                    hold_write[i] <= m_HWRITE[i];
                    hold_size[i]  <= m_HSIZE[3*i +: 3];
                    hold_burst[i] <= m_HBURST[3*i +: 3];
                end
                case (st[i])
                    P_IDLE: begin
                        if (cap[i]) st[i] <= P_PEND;
                    end
                    P_PEND: begin
                        if (s_HREADYOUT && win_vld && (win_idx == PW'(i))) st[i] <= P_ADDR;
                    end
                    P_ADDR: begin
                        if (s_HREADYOUT) st[i] <= P_DATA;
                    end
                    P_DATA: begin
                        if (s_HREADYOUT) st[i] <= cap[i] ? P_PEND : P_IDLE;
                    end
                    default: st[i] <= P_IDLE;
                endcase
            end

            if (lock_done) begin
                lock <= 1'b0;
            end

            if (s_HREADYOUT) begin
                if (win_vld) begin
                    s_HTRANS <= HTRANS_NONSEQ;
                    s_HADDR  <= hold_addr[win_idx];
                    s_HWRITE <= hold_write[win_idx];
                    s_HSIZE  <= hold_size[win_idx];
                    grant    <= N'(1) << win_idx;
                    rr_ptr   <= win_idx;
                    if (|hold_burst[win_idx]) begin
                        lock      <= 1'b1;
                        lock_port <= win_idx;
                    end
                end else begin
                    s_HTRANS <= HTRANS_IDLE;
                    grant    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Directed bench for ahb_manager_arbiter with three manager ports and a scripted subordinate.
module tb_ahb_manager_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              HCLK;
    logic              HRESET;
    logic [2*N-1:0]    m_HTRANS;
    logic [AW*N-1:0]   m_HADDR;
    logic [N-1:0]      m_HWRITE;
    logic [3*N-1:0]    m_HSIZE;
    logic [3*N-1:0]    m_HBURST;
    logic [DW*N-1:0]   m_HWDATA;
    logic [DW-1:0]     m_HRDATA;
    logic [N-1:0]      m_HREADY;
    logic [N-1:0]      m_HRESP;
    logic [1:0]        s_HTRANS;
    logic [AW-1:0]     s_HADDR;
    logic              s_HWRITE;
    logic [2:0]        s_HSIZE;
    logic [2:0]        s_HBURST;
    logic [DW-1:0]     s_HWDATA;
    logic              s_HREADY;
    logic [DW-1:0]     s_HRDATA;
    logic              s_HREADYOUT;
    logic              s_HRESP;
    logic [N-1:0]      grant;

    int n_checks;
    int n_pass;

    ahb_manager_arbiter #(
        .NUM_MANAGERS(N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .m_HTRANS    (m_HTRANS),
        .m_HADDR     (m_HADDR),
        .m_HWRITE    (m_HWRITE),
        .m_HSIZE     (m_HSIZE),
        .m_HBURST    (m_HBURST),
        .m_HWDATA    (m_HWDATA),
        .m_HRDATA    (m_HRDATA),
        .m_HREADY    (m_HREADY),
        .m_HRESP     (m_HRESP),
        .s_HTRANS    (s_HTRANS),
        .s_HADDR     (s_HADDR),
        .s_HWRITE    (s_HWRITE),
        .s_HSIZE     (s_HSIZE),
        .s_HBURST    (s_HBURST),
        .s_HWDATA    (s_HWDATA),
        .s_HREADY    (s_HREADY),
        .s_HRDATA    (s_HRDATA),
        .s_HREADYOUT (s_HREADYOUT),
        .s_HRESP     (s_HRESP),
        .grant       (grant)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input int p, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic [2:0] burst, input logic [31:0] wdata);
        m_HTRANS[2*p +: 2]  = trans;
        m_HADDR[AW*p +: AW] = addr;
        m_HWRITE[p]         = wr;
        m_HSIZE[3*p +: 3]   = 3'd2;
        m_HBURST[3*p +: 3]  = burst;
        m_HWDATA[DW*p +: DW] = wdata;
    endtask

    task automatic set_trans(input int p, input logic [1:0] trans);
        m_HTRANS[2*p +: 2] = trans;
    endtask

    task automatic do_reset();
        HRESET      = 1'b1;
        m_HTRANS    = '0;
        m_HADDR     = '0;
        m_HWRITE    = '0;
        m_HSIZE     = '0;
        m_HBURST    = '0;
        m_HWDATA    = '0;
        s_HRDATA    = '0;
        s_HREADYOUT = 1'b1;
        s_HRESP     = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [2:0]  rr_exp [6];
        logic [2:0]  bu_g_exp [5];
        logic [31:0] bu_a_exp [5];
        logic [2:0]  bu_g [5];
        logic [31:0] bu_a [5];
        logic [2:0]  bu_b [5];
        int          nis;
        int          sent;

        n_checks = 0;
        n_pass   = 0;
        rr_exp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bu_g_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
        bu_a_exp = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h500};

        // Reset values
        HRESET      = 1'b1;
        m_HTRANS    = '0;
        m_HADDR     = '0;
        m_HWRITE    = '0;
        m_HSIZE     = '0;
        m_HBURST    = '0;
        m_HWDATA    = '0;
        s_HRDATA    = '0;
        s_HREADYOUT = 1'b1;
        s_HRESP     = 1'b0;
        step();
        chk("rst_htrans", 64'(s_HTRANS), 64'd0);
        chk("rst_haddr",  64'(s_HADDR),  64'd0);
        chk("rst_grant",  64'(grant),    64'd0);
        chk("rst_hready", 64'(m_HREADY), 64'b111);
        chk("rst_hresp",  64'(m_HRESP),  64'd0);
        chk("rst_hburst", 64'(s_HBURST), 64'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Single read from port 0
        s_HRDATA = 32'hCAFEF00D;
        drive(0, 2'b10, 32'h1000, 1'b0, 3'd0, 32'h0);
        step();
        chk("rd_pend_hready", 64'(m_HREADY[0]), 64'd0);
        chk("rd_pend_htrans", 64'(s_HTRANS), 64'd0);
        set_trans(0, 2'b00);
        step();
        chk("rd_htrans", 64'(s_HTRANS), 64'd2);
        chk("rd_haddr",  64'(s_HADDR),  64'h1000);
        chk("rd_grant",  64'(grant),    64'b001);
        chk("rd_addr_hready", 64'(m_HREADY[0]), 64'd0);
        step();
        chk("rd_hready", 64'(m_HREADY[0]), 64'd1);
        chk("rd_hrdata", 64'(m_HRDATA), 64'hCAFEF00D);
        chk("rd_idle",   64'(s_HTRANS), 64'd0);
        step();

        // Reset asserted while port 0 is in its write data phase
        do_reset();
        drive(0, 2'b10, 32'h44, 1'b1, 3'd0, 32'h12345678);
        step();
        set_trans(0, 2'b00);
        step();
        chk("rw_haddr", 64'(s_HADDR), 64'h44);
        step();
        s_HREADYOUT = 1'b0;
        #1;
        chk("rw_hwdata", 64'(s_HWDATA), 64'h12345678);
        chk("rw_stall",  64'(m_HREADY[0]), 64'd0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rw_rst_htrans", 64'(s_HTRANS), 64'd0);
        chk("rw_rst_haddr",  64'(s_HADDR),  64'd0);
        chk("rw_rst_grant",  64'(grant),    64'd0);
        chk("rw_rst_hready", 64'(m_HREADY), 64'b111);
        chk("rw_rst_hresp",  64'(m_HRESP),  64'd0);
        chk("rw_rst_hwdata", 64'(s_HWDATA), 64'd0);
        s_HREADYOUT = 1'b1;
        set_trans(0, 2'b00);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Two ports request at the same edge
        drive(0, 2'b10, 32'h10, 1'b1, 3'd0, 32'hAAAA0010);
        drive(1, 2'b10, 32'h20, 1'b1, 3'd0, 32'hBBBB0020);
        step();
        set_trans(0, 2'b00);
        set_trans(1, 2'b00);
        step();
        chk("bp_addr0",   64'(s_HADDR),  64'h10);
        chk("bp_grant0",  64'(grant),    64'b001);
        chk("bp_hwdata0", 64'(s_HWDATA), 64'd0);
        step();
        chk("bp_addr1",   64'(s_HADDR),  64'h20);
        chk("bp_grant1",  64'(grant),    64'b010);
        chk("bp_hwdata1", 64'(s_HWDATA), 64'hAAAA0010);
        chk("bp_hready",  64'(m_HREADY), 64'b101);
        step();
        chk("bp_hwdata2", 64'(s_HWDATA), 64'hBBBB0020);
        chk("bp_grant2",  64'(grant),    64'd0);
        chk("bp_htrans2", 64'(s_HTRANS), 64'd0);
        step();

        // Sustained requests from all three ports
        do_reset();
        for (int p = 0; p < 3; p++) drive(p, 2'b10, 32'(32'h100 * (p + 1)), 1'b0, 3'd0, 32'h0);
        step();
        for (int j = 0; j < 6; j++) begin
            step();
            chk("rr_grant",  64'(grant),    64'(rr_exp[j]));
            chk("rr_htrans", 64'(s_HTRANS), 64'd2);
        end

        // Port 1 INCR4 burst while port 0 waits
        do_reset();
        nis  = 0;
        sent = 1;
        drive(1, 2'b10, 32'h100, 1'b0, 3'd3, 32'h0);
        step();
        drive(0, 2'b10, 32'h500, 1'b0, 3'd0, 32'h0);
        for (int c = 0; c < 40 && nis < 5; c++) begin
            step();
            if (m_HREADY[0] == 1'b0) set_trans(0, 2'b00);
            if (s_HTRANS == 2'b10) begin
                bu_g[nis] = grant;
                bu_a[nis] = s_HADDR;
                bu_b[nis] = s_HBURST;
                nis++;
            end
            if (m_HREADY[1]) begin
                if (sent < 4) begin
                    drive(1, 2'b11, 32'(32'h100 + 4 * sent), 1'b0, 3'd3, 32'h0);
                    sent++;
                end else begin
                    set_trans(1, 2'b00);
                end
            end
        end
        chk("bu_count", 64'(nis), 64'd5);
        for (int j = 0; j < nis; j++) begin
            chk("bu_grant",  64'(bu_g[j]), 64'(bu_g_exp[j]));
            chk("bu_haddr",  64'(bu_a[j]), 64'(bu_a_exp[j]));
            chk("bu_hburst", 64'(bu_b[j]), 64'd0);
        end

        // Two-cycle error response on a port-0 write, port 1 already in its address phase
        do_reset();
        drive(0, 2'b10, 32'h30, 1'b1, 3'd0, 32'hDEAD0030);
        step();
        set_trans(0, 2'b00);
        drive(1, 2'b10, 32'h40, 1'b0, 3'd0, 32'h0);
        step();
        set_trans(1, 2'b00);
        step();
        s_HRESP     = 1'b1;
        s_HREADYOUT = 1'b0;
        #1;
        chk("er_resp0_a", 64'(m_HRESP[0]),  64'd1);
        chk("er_rdy0_a",  64'(m_HREADY[0]), 64'd0);
        chk("er_resp1_a", 64'(m_HRESP[1]),  64'd0);
        step();
        s_HREADYOUT = 1'b1;
        #1;
        chk("er_resp0_b", 64'(m_HRESP[0]),  64'd1);
        chk("er_rdy0_b",  64'(m_HREADY[0]), 64'd1);
        chk("er_resp1_b", 64'(m_HRESP[1]),  64'd0);
        chk("er_grant",   64'(grant),       64'b010);
        step();
        s_HRESP = 1'b0;
        #1;
        chk("er_resp_c", 64'(m_HRESP),     64'd0);
        chk("er_rdy1_c", 64'(m_HREADY[1]), 64'd1);
        chk("er_addr_c", 64'(s_HADDR),     64'h40);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
